clk_reset_sequencer: RTL and testbench
======================================

# clk_reset_sequencer

Parametrised clock-domain bring-up sequencer for the ULX3S build. It runs on the free-running 25 MHz board clock and drives the PLL reset and PLL configuration select. It filters the PLL lock signal and releases N per-domain resets in a staggered order. It also handles runtime fast/slow PLL mode switching and lock-loss recovery, and counts lock-loss events.

## Interface
Parameters:
- CHANNELS, 3: number of downstream domain resets (1..8).
- PLL_RESET_CYCLES, 32: cycles `pll_reset` is held high per PLL restart (≥1).
- LOCK_FILTER_CYCLES, 1024: consecutive cycles synced lock must stay high before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles in WAIT_LOCK without a qualified lock before the PLL is restarted (> LOCK_FILTER_CYCLES).
- STAGGER_CYCLES, 16: cycles between successive channel releases (≥1).
- MODE_DEFAULT, 1: `pll_sel` value after reset (1 = fast 33.75 MHz config, 0 = 25 MHz config).

Ports:
- clk_25m  in  1  board clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  raw PLL lock, asynchronous; passed through a 2-flop synchroniser internally.
- mode_req  in  1  requested `pll_sel` value.
- mode_req_valid  in  1  request strobe.
- mode_req_ready  out  1  combinational: (state == RUN) && locked_sync.
- pll_reset  out  1  active-high PLL reset.
- pll_sel  out  1  PLL configuration select.
- domain_reset  out  CHANNELS  active-high per-domain resets; each consumer resynchronises its own bit.
- ready  out  1  all domains released and running.
- lock_loss_count  out  8  saturating count of lock losses seen in RUN.

## Operation
- States: PLL_RST, WAIT_LOCK, RELEASE, RUN.
- Reset (reset_n low at a rising edge): state PLL_RST, cycle counter 0, `pll_reset`=1, `pll_sel`=MODE_DEFAULT, `domain_reset`=all 1s, `ready`=0, `lock_loss_count`=0, synchroniser flops 0.
- PLL_RST: `pll_reset`=1 and `domain_reset`=all 1s. After PLL_RESET_CYCLES cycles, clear the counter and go to WAIT_LOCK.
- WAIT_LOCK: `pll_reset`=0.
  - A filter counter increments while locked_sync=1 and clears to 0 when locked_sync=0.
  - When the filter count reaches LOCK_FILTER_CYCLES, go to RELEASE.
  - A timeout counter runs from state entry. When it reaches LOCK_TIMEOUT_CYCLES with no qualified lock, go to PLL_RST.
  - If the lock qualifies on the same cycle as the timeout, the lock wins.
- RELEASE: clear `domain_reset[0]` on entry. Clear `domain_reset[i]` STAGGER_CYCLES cycles after `domain_reset[i-1]`. One cycle after the last bit clears, go to RUN and set `ready`=1.
  - If locked_sync falls during RELEASE: set all resets to 1, go to PLL_RST. `lock_loss_count` is not incremented.
- RUN:
  - Lock loss: locked_sync=0. On the next edge, set all `domain_reset` to 1, `ready`=0, increment `lock_loss_count` (saturate at 255), go to PLL_RST. `pll_sel` is unchanged.
  - Mode handshake: a transfer occurs on an edge where mode_req_valid && mode_req_ready.
    - If `mode_req` != `pll_sel`: latch `pll_sel`=`mode_req`, set all resets to 1, `ready`=0, go to PLL_RST.
    - If equal: accept with no side effect, stay in RUN.
  - Lock loss and a mode request in the same cycle: `mode_req_ready`=0, so lock loss wins and the request stays pending.
- Outside RUN, `mode_req_valid` is ignored; the requester holds it until accepted.
- Counter widths are $clog2(param+1). No counter wraps; each is cleared on every state entry.

## Timing
- All outputs except `mode_req_ready` are registered.
- `pll_locked` → locked_sync latency: 2 cycles.
- After reset_n is first sampled high:
  - `pll_reset` stays 1 for exactly PLL_RESET_CYCLES cycles.
  - `domain_reset[0]` falls LOCK_FILTER_CYCLES+1 edges after the first edge at which locked_sync=1 in WAIT_LOCK, provided lock stays high.
  - `domain_reset[k]` falls k·STAGGER_CYCLES edges after `domain_reset[0]`.
  - `ready` rises 1 edge after `domain_reset[CHANNELS-1]` falls.
- Lock loss in RUN: resets assert and `ready` deasserts 1 edge after locked_sync=0, which is 3 edges after `pll_locked` falls.
- Mode change: `pll_sel` and resets update on the handshake edge; `pll_reset` rises on the same edge.
- reset_n low mid-sequence, in any state: all outputs return to reset values on that edge. `lock_loss_count` also clears.

## Test plan
Bench parameters: CHANNELS=3, PLL_RESET_CYCLES=4, LOCK_FILTER_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, STAGGER_CYCLES=2, MODE_DEFAULT=1.
- Cold boot: release reset, raise `pll_locked` at cycle 10.
  - `pll_reset` is high for cycles 0–3.
  - `domain_reset` goes 3'b111→110→100→000 at 2-cycle spacing.
  - `ready`=1 one cycle later; `pll_sel`=1.
- Glitchy lock: `pll_locked` pulses high for 5 cycles, low for 1, then stays high.
  - The filter restarts at the glitch.
  - Release happens 8 cycles after sustained lock, not before.
- Timeout: hold `pll_locked`=0.
  - `pll_reset` re-pulses every 4+64 cycles.
  - `domain_reset` stays 3'b111 and `ready`=0 throughout.
- Lock loss in RUN: drop `pll_locked` for 1 cycle, three times.
  - Each drop gives all resets asserted 3 cycles after the drop and a full re-sequence.
  - `lock_loss_count` reads 3. A separate force of 256 losses shows it saturates at 255.
- Mode switch in RUN:
  - `mode_req`=0 with valid: accepted, `pll_sel`=0, PLL restarted, domains re-released.
  - `mode_req`=0 again: accepted with no reset.
  - Request asserted during RELEASE: not accepted until `ready`=1.
- Simultaneous lock loss and mode request:
  - `mode_req_ready`=0 that cycle and `pll_sel` is unchanged.
  - The count increments.
  - The held request is accepted after re-lock.

Source files
------------

// File: rtl/clk_reset_sequencer.sv
// Clock-domain bring-up sequencer: holds the PLL in reset, qualifies its lock
// with a consecutive-cycle filter, releases per-domain resets one at a time,
// and restarts the PLL on lock loss, lock timeout or a runtime mode change.
module clk_reset_sequencer #(
    parameter int   CHANNELS            = 3,
    parameter int   PLL_RESET_CYCLES    = 32,
    parameter int   LOCK_FILTER_CYCLES  = 1024,
    parameter int   LOCK_TIMEOUT_CYCLES = 65536,
    parameter int   STAGGER_CYCLES      = 16,
    parameter logic MODE_DEFAULT        = 1'b1
) (
    input  logic                clk_25m,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic                mode_req,
    input  logic                mode_req_valid,
    output logic                mode_req_ready,
    output logic                pll_reset,
    output logic                pll_sel,
    output logic [CHANNELS-1:0] domain_reset,
    output logic                ready,
    output logic [7:0]          lock_loss_count
);

    localparam int RST_W  = $clog2(PLL_RESET_CYCLES + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);

    localparam logic [RST_W-1:0]    RST_LAST  = RST_W'(PLL_RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0]   FILT_DONE = FILT_W'(LOCK_FILTER_CYCLES);
    localparam logic [STG_W-1:0]    STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [CHANNELS-1:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_t;

    state_t              state, state_nxt;
    logic [RST_W-1:0]    rst_cnt, rst_cnt_nxt;
    logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
    logic [FILT_W-1:0]   filt_cnt, filt_cnt_nxt;
    logic [STG_W-1:0]    stg_cnt, stg_cnt_nxt;
    logic                pll_reset_nxt;
    logic                pll_sel_nxt;
    logic [CHANNELS-1:0] dreset_nxt;
    logic                ready_nxt;
    logic [7:0]          llc_nxt;

    logic sync_p0, sync_p1;
    logic locked_sync;

    // Lock-loss counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk_25m) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pll_locked;
            sync_p1 <= sync_p0;
        end
    end

    assign locked_sync    = sync_p1;
    assign mode_req_ready = (state == RUN) && locked_sync;

    // State, counters and registered outputs.
    always_ff @(posedge clk_25m) begin
        if (!reset_n) begin
            state           <= PLL_RST;
            rst_cnt         <= '0;
            to_cnt          <= '0;
            filt_cnt        <= '0;
            stg_cnt         <= '0;
            pll_reset       <= 1'b1;
            pll_sel         <= MODE_DEFAULT;
            domain_reset    <= ALL_ONES;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state           <= state_nxt;
            rst_cnt         <= rst_cnt_nxt;
            to_cnt          <= to_cnt_nxt;
            filt_cnt        <= filt_cnt_nxt;
            stg_cnt         <= stg_cnt_nxt;
            pll_reset       <= pll_reset_nxt;
            pll_sel         <= pll_sel_nxt;
            domain_reset    <= dreset_nxt;
            ready           <= ready_nxt;
            lock_loss_count <= llc_nxt;
        end
    end

    // Next-state and next-output logic; counters default to zero so every
    // state entry starts them cleared.
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = '0;
        to_cnt_nxt    = '0;
        filt_cnt_nxt  = '0;
        stg_cnt_nxt   = '0;
        pll_reset_nxt = pll_reset;
        pll_sel_nxt   = pll_sel;
        dreset_nxt    = domain_reset;
        ready_nxt     = ready;
        llc_nxt       = lock_loss_count;

        case (state)
            PLL_RST: begin
                pll_reset_nxt = 1'b1;
                dreset_nxt    = ALL_ONES;
                ready_nxt     = 1'b0;
                if (rst_cnt == RST_LAST) begin
                    state_nxt     = WAIT_LOCK;
                    pll_reset_nxt = 1'b0;
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end

            WAIT_LOCK: begin
                // A fully qualified lock takes priority over the timeout.
                if (filt_cnt == FILT_DONE) begin
                    state_nxt  = RELEASE;
                    dreset_nxt = ALL_ONES << 1;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt     = PLL_RST;
                    pll_reset_nxt = 1'b1;
                end else begin
                    to_cnt_nxt   = to_cnt + TO_W'(1);
                    filt_cnt_nxt = locked_sync ? filt_cnt + FILT_W'(1) : '0;
                end
            end

            RELEASE: begin
                if (!locked_sync) begin
                    state_nxt     = PLL_RST;
                    pll_reset_nxt = 1'b1;
                    dreset_nxt    = ALL_ONES;
                end else if (domain_reset == '0) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end else if (stg_cnt == STG_LAST) begin
                    // Shifting in a zero releases the next channel in order.
                    dreset_nxt = domain_reset << 1;
                end else begin
                    stg_cnt_nxt = stg_cnt + STG_W'(1);
                end
            end

            RUN: begin
                if (!locked_sync) begin
                    state_nxt     = PLL_RST;
                    pll_reset_nxt = 1'b1;
                    dreset_nxt    = ALL_ONES;
                    ready_nxt     = 1'b0;
                    llc_nxt       = sat_inc(lock_loss_count);
                end else if (mode_req_valid && (mode_req != pll_sel)) begin
                    pll_sel_nxt   = mode_req;
                    state_nxt     = PLL_RST;
                    pll_reset_nxt = 1'b1;
                    dreset_nxt    = ALL_ONES;
                    ready_nxt     = 1'b0;
                end
            end

            default: begin
                state_nxt = PLL_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: boot, glitch and timeout vector tables plus
// hand-written sequences for lock loss, mode handshakes and saturation.
module tb_clk_reset_sequencer;

    localparam int CH  = 3;
    localparam int PRC = 4;
    localparam int LFC = 8;
    localparam int LTC = 64;
    localparam int STG = 2;
    // Edges from the restart edge until ready, with lock already held high.
    localparam int RESEQ_EDGES = PRC + 1 + LFC + 2 * STG + 1;

    logic          clk_25m = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          mode_req = 1'b1;
    logic          mode_req_valid = 1'b0;
    logic          mode_req_ready;
    logic          pll_reset;
    logic          pll_sel;
    logic [CH-1:0] domain_reset;
    logic          ready;
    logic [7:0]    lock_loss_count;

    always #5 clk_25m = ~clk_25m;

    clk_reset_sequencer #(
        .CHANNELS            (CH),
        .PLL_RESET_CYCLES    (PRC),
        .LOCK_FILTER_CYCLES  (LFC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .STAGGER_CYCLES      (STG),
        .MODE_DEFAULT        (1'b1)
    ) dut (
        .clk_25m         (clk_25m),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .mode_req        (mode_req),
        .mode_req_valid  (mode_req_valid),
        .mode_req_ready  (mode_req_ready),
        .pll_reset       (pll_reset),
        .pll_sel         (pll_sel),
        .domain_reset    (domain_reset),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    typedef struct {
        logic       lock;
        logic       mreq;
        logic       mvld;
        logic [6:0] exp;   // {pll_reset, pll_sel, domain_reset, ready, mode_req_ready}
    } vec_t;

    vec_t       vecs[200];
    int         nvec;
    logic [6:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_llc = 0;
    int         e;

    function automatic logic [6:0] outs();
        return {pll_reset, pll_sel, domain_reset, ready, mode_req_ready};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25m);
        #1;
    endtask

    // Expected outputs after edge n of a boot whose sustained lock is driven
    // from edge 'rise' onward: locked_sync rises one edge later, domain 0
    // releases LFC+1 edges after that, then one channel every STG edges.
    function automatic logic [6:0] boot_exp(input int n, input int rise);
        int         r0;
        logic [2:0] dr;
        logic       rd;
        r0 = rise + 1 + LFC + 1;
        if (n < r0)                dr = 3'b111;
        else if (n < r0 + STG)     dr = 3'b110;
        else if (n < r0 + 2 * STG) dr = 3'b100;
        else                       dr = 3'b000;
        rd = (n >= r0 + 2 * STG + 1);
        return {(n < PRC), 1'b1, dr, rd, rd};
    endfunction

    task automatic build_boot(input int rise, input int g_lo, input int g_hi);
        nvec = rise + 1 + LFC + 1 + 8;
        for (int i = 0; i < nvec; i++) begin
            vecs[i].lock = ((i + 1) >= rise) || (((i + 1) >= g_lo) && ((i + 1) <= g_hi));
            vecs[i].mreq = 1'b1;
            vecs[i].mvld = 1'b0;
            vecs[i].exp  = boot_exp(i + 1, rise);
        end
    endtask

    task automatic apply_table(input string name);
        logic [6:0] want;
        for (int i = 0; i < nvec; i++) begin
            pll_locked     = vecs[i].lock;
            mode_req       = vecs[i].mreq;
            mode_req_valid = vecs[i].mvld;
            exp_q.push_back(vecs[i].exp);
            tick();
            want = exp_q.pop_front();
            check($sformatf("%s[%0d]", name, i + 1), outs(), want);
        end
    endtask

    task automatic do_reset(input string name);
        reset_n        = 1'b0;
        pll_locked     = 1'b0;
        mode_req_valid = 1'b0;
        mode_req       = 1'b1;
        tick();
        check({name, "_outs"}, outs(), 7'b1_1_111_0_0);
        check({name, "_llc"}, lock_loss_count, 0);
        exp_llc = 0;
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int budget, output int edges);
        edges = 0;
        while (!ready && edges < budget) begin
            tick();
            edges++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready still 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    // One-cycle drop of the raw lock while in RUN.
    task automatic drop_lock(input string name, input bit full);
        int n;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        if (full)
            check({name, "_pre"}, {domain_reset, ready, mode_req_ready}, 5'b000_1_0);
        tick();
        exp_llc = (exp_llc == 255) ? 255 : exp_llc + 1;
        if (full)
            check({name, "_assert"}, {pll_reset, domain_reset, ready}, 5'b1_111_0);
        check({name, "_llc"}, lock_loss_count, exp_llc);
        wait_ready(name, 200, n);
        if (full)
            check({name, "_reseq"}, n, RESEQ_EDGES);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Cold boot: lock raised at cycle 10.
        do_reset("rst0");
        build_boot(10, 1000, 0);
        apply_table("boot");

        // Three single-cycle lock drops in RUN.
        for (int k = 0; k < 3; k++)
            drop_lock($sformatf("loss%0d", k), 1'b1);
        check("loss_count3", lock_loss_count, 3);

        // Mode switch to the slow configuration.
        check("mode_rdy", mode_req_ready, 1);
        mode_req = 1'b0;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        check("mode_switch", {pll_reset, pll_sel, domain_reset, ready}, 6'b1_0_111_0);
        wait_ready("mode_reseq", 200, e);
        check("mode_reseq_edges", e, RESEQ_EDGES);

        // Same value again: accepted, nothing restarts.
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        check("mode_same", outs(), 7'b0_0_000_1_1);
        tick();
        check("mode_same_hold", outs(), 7'b0_0_000_1_1);

        // Switch back to fast, then hold a request through RELEASE.
        mode_req = 1'b1;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        check("mode_fast", {pll_reset, pll_sel}, 2'b11);
        e = 0;
        while (domain_reset == 3'b111 && e < 100) begin
            tick();
            e++;
        end
        check("reach_release", domain_reset, 3'b110);
        mode_req = 1'b0;
        mode_req_valid = 1'b1;
        e = 0;
        while (!ready && e < 100) begin
            check("release_hold", {pll_sel, mode_req_ready}, 2'b10);
            tick();
            e++;
        end
        check("release_ready", {ready, pll_sel, mode_req_ready}, 3'b111);
        tick();
        mode_req_valid = 1'b0;
        check("release_accept", {pll_reset, pll_sel, ready}, 3'b100);
        wait_ready("release_reseq", 200, e);

        // Lock loss together with a pending mode request.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("simul_rdy_low", mode_req_ready, 0);
        mode_req = 1'b1;
        mode_req_valid = 1'b1;
        tick();
        exp_llc++;
        check("simul_lockloss", {pll_reset, pll_sel, domain_reset, ready}, 6'b1_0_111_0);
        check("simul_count", lock_loss_count, exp_llc);
        wait_ready("simul_reseq", 200, e);
        check("simul_pending", {pll_sel, mode_req_ready}, 2'b01);
        tick();
        mode_req_valid = 1'b0;
        check("simul_accept", {pll_reset, pll_sel}, 2'b11);
        wait_ready("simul_reseq2", 200, e);

        // Saturation: drive the count up to 255, then one more loss.
        while (exp_llc < 255)
            drop_lock("sat", 1'b0);
        check("sat_255", lock_loss_count, 255);
        drop_lock("sat_extra", 1'b0);
        check("sat_hold", lock_loss_count, 255);

        // Move to slow mode, then reset mid-run: everything must clear.
        mode_req = 1'b0;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        wait_ready("pre_reset", 200, e);
        check("pre_reset_sel", pll_sel, 0);

        // Glitchy lock: high 5 cycles, low 1, then sustained from edge 12.
        do_reset("rst1");
        build_boot(12, 6, 10);
        apply_table("glitch");

        // Lock never arrives: PLL restarts every PRC+LTC cycles.
        do_reset("rst2");
        nvec = 150;
        for (int i = 0; i < nvec; i++) begin
            vecs[i].lock = 1'b0;
            vecs[i].mreq = 1'b1;
            vecs[i].mvld = 1'b1;
            vecs[i].exp  = {(((i + 1) % (PRC + LTC)) < PRC), 1'b1, 3'b111, 1'b0, 1'b0};
        end
        apply_table("timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
